// File: rtl/i2c_eeprom_pkg.sv
// ---------------------------------------------------------------------------
// i2c_eeprom_pkg
// Shared types and constants for the clocked I2C EEPROM slave.
//   state_t     : protocol FSM states
//   CTRL_RW_BIT : position of the R/W flag in the control byte
//   BLOCK_LSB   : lowest bit of the 3-bit block-select field in the control byte
// ---------------------------------------------------------------------------
package i2c_eeprom_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CTRL,
        CTRL_ACK,
        ADDR,
        ADDR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK
    } state_t;

    localparam int unsigned CTRL_RW_BIT = 0;
    localparam int unsigned BLOCK_LSB   = 1;

endpackage

// File: rtl/i2c_line_cond.sv
// ---------------------------------------------------------------------------
// i2c_line_cond
// Synchronises the raw SCL/SDA pin levels into the clk domain and derives
// bus events from the synchronised previous/current levels.
// Ports:
//   clk, rst_n    : system clock, synchronous active-low reset
//   scl_i, sda_i  : raw pin levels
//   sda           : synchronised SDA level
//   scl_rise      : one-clk strobe, SCL went 0->1
//   scl_fall      : one-clk strobe, SCL went 1->0
//   start         : SDA fell while SCL stayed high
//   stop          : SDA rose while SCL stayed high
// ---------------------------------------------------------------------------
module i2c_line_cond #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_prev;
    logic                   sda_prev;
    logic                   scl;

    // Reset to the idle-bus level so leaving reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_prev <= scl;
            sda_prev <= sda;
        end
    end

    assign scl      = scl_sync[SYNC_STAGES-1];
    assign sda      = sda_sync[SYNC_STAGES-1];
    assign scl_rise =  scl & ~scl_prev;
    assign scl_fall = ~scl &  scl_prev;
    assign start    =  scl &  scl_prev &  sda_prev & ~sda;
    assign stop     =  scl &  scl_prev & ~sda_prev &  sda;

endmodule

// File: rtl/i2c_eeprom_slave.sv
// ---------------------------------------------------------------------------
// i2c_eeprom_slave
// Clocked I2C slave memory: byte/page write, current-address, random and
// sequential read, ACK/NACK generation and open-drain SDA drive.
// Ports:
//   clk       : system clock (>= 16x SCL)
//   rst_n     : synchronous active-low reset
//   scl_i     : SCL pin level
//   sda_i     : SDA pin level
//   wp        : write protect (only when WRITE_PROTECT_EN is defined)
//   sda_oe    : 1 = pull SDA low, 0 = release
//   busy      : device addressed, transfer in progress
//   wr_pulse  : one-clk pulse per byte committed to memory
//   cur_addr  : internal address pointer
// Build option: define WRITE_PROTECT_EN to add the wp input; while wp=1
// data bytes are NACKed and not written.
// ---------------------------------------------------------------------------
module i2c_eeprom_slave
    import i2c_eeprom_pkg::*;
#(
    parameter int unsigned ADDR_W      = 11,
    parameter logic [3:0]  DEV_ID      = 4'b1010,
    parameter int unsigned PAGE_W      = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              scl_i,
    input  logic              sda_i,
`ifdef WRITE_PROTECT_EN
    input  logic              wp,
`endif
    output logic              sda_oe,
    output logic              busy,
    output logic              wr_pulse,
    output logic [ADDR_W-1:0] cur_addr
);

    localparam logic [ADDR_W-1:0] PAGE_MASK = ADDR_W'((32'd1 << PAGE_W) - 32'd1);

    logic sda_lvl, scl_rise, scl_fall, start_det, stop_det;

    i2c_line_cond #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_line (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .sda      (sda_lvl),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start_det),
        .stop     (stop_det)
    );

    logic wp_s;
`ifdef WRITE_PROTECT_EN
    logic [SYNC_STAGES-1:0] wp_sync;
    always_ff @(posedge clk) begin
        if (!rst_n) wp_sync <= '0;
        else        wp_sync <= {wp_sync[SYNC_STAGES-2:0], wp};
    end
    assign wp_s = wp_sync[SYNC_STAGES-1];
`else
    assign wp_s = 1'b0;
`endif

    state_t            state, state_nxt;
    logic [3:0]        bit_cnt, bit_cnt_nxt;
    logic [7:0]        shreg, shreg_nxt;
    logic [ADDR_W-1:0] addr_nxt, addr_page_inc;
    logic              oe_nxt, busy_nxt, wr_nxt;
    logic [7:0]        wr_data, wdata_nxt;
    logic [7:0]        rd_data;
    logic              rw, rw_nxt;
    logic              nack, nack_nxt;
    logic [7:0]        byte_in;
    logic [10:0]       blk_full;

    logic [7:0] mem [0:(1 << ADDR_W) - 1];

    // Page write only advances the in-page bits; upper bits stay put.
    assign addr_page_inc = (cur_addr & ~PAGE_MASK) | ((cur_addr + ADDR_W'(1)) & PAGE_MASK);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            cur_addr <= '0;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            wr_pulse <= 1'b0;
            wr_data  <= '0;
            rw       <= 1'b0;
            nack     <= 1'b0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shreg    <= shreg_nxt;
            cur_addr <= addr_nxt;
            sda_oe   <= oe_nxt;
            busy     <= busy_nxt;
            wr_pulse <= wr_nxt;
            wr_data  <= wdata_nxt;
            rw       <= rw_nxt;
            nack     <= nack_nxt;
        end
    end

    // Single-port memory; the write lands the clk after the 8th data rise,
    // addressed by the pointer before its increment.
    always_ff @(posedge clk) begin
        if (wr_pulse) mem[cur_addr] <= wr_data;
        rd_data <= mem[cur_addr];
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        addr_nxt    = cur_addr;
        oe_nxt      = sda_oe;
        busy_nxt    = busy;
        wr_nxt      = 1'b0;
        wdata_nxt   = wr_data;
        rw_nxt      = rw;
        nack_nxt    = nack;
        byte_in     = {shreg[6:0], sda_lvl};
        // Block bits sit above the word byte; slicing drops unused ones.
        blk_full    = {byte_in[BLOCK_LSB +: 3], cur_addr[7:0]};

        if (wr_pulse) addr_nxt = addr_page_inc;

        if (stop_det) begin
            state_nxt   = IDLE;
            busy_nxt    = 1'b0;
            oe_nxt      = 1'b0;
            bit_cnt_nxt = '0;
        end else if (start_det) begin
            state_nxt   = CTRL;
            oe_nxt      = 1'b0;
            bit_cnt_nxt = '0;
        end else begin
            case (state)
                IDLE: ;

                CTRL: if (scl_rise) begin
                    shreg_nxt   = byte_in;
                    bit_cnt_nxt = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        bit_cnt_nxt = '0;
                        if (byte_in[7:4] == DEV_ID) begin
                            state_nxt = CTRL_ACK;
                            busy_nxt  = 1'b1;
                            rw_nxt    = byte_in[CTRL_RW_BIT];
                            addr_nxt  = blk_full[ADDR_W-1:0];
                        end else begin
                            state_nxt = IDLE;
                            busy_nxt  = 1'b0;
                        end
                    end
                end

                ADDR: if (scl_rise) begin
                    shreg_nxt   = byte_in;
                    bit_cnt_nxt = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        bit_cnt_nxt   = '0;
                        addr_nxt[7:0] = byte_in;
                        state_nxt     = ADDR_ACK;
                    end
                end

                WDATA: if (scl_rise) begin
                    shreg_nxt   = byte_in;
                    bit_cnt_nxt = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        bit_cnt_nxt = '0;
                        wdata_nxt   = byte_in;
                        nack_nxt    = wp_s;
                        wr_nxt      = ~wp_s;
                        state_nxt   = WDATA_ACK;
                    end
                end

                // bit_cnt doubles as the ACK phase: 0 = before the ACK clock,
                // 1 = ACK clock in progress.
                CTRL_ACK, ADDR_ACK, WDATA_ACK: if (scl_fall) begin
                    if (bit_cnt == 4'd0) begin
                        oe_nxt      = !(state == WDATA_ACK && nack);
                        bit_cnt_nxt = 4'd1;
                    end else begin
                        oe_nxt      = 1'b0;
                        bit_cnt_nxt = '0;
                        if (state == CTRL_ACK && rw) begin
                            state_nxt = RDATA;
                            shreg_nxt = rd_data;
                            oe_nxt    = ~rd_data[7];
                        end else if (state == CTRL_ACK) begin
                            state_nxt = ADDR;
                        end else begin
                            state_nxt = WDATA;
                        end
                    end
                end

                // MSB is already on the line at entry; each fall presents the
                // next bit until 8 rises have been seen.
                RDATA: if (scl_rise) begin
                    bit_cnt_nxt = bit_cnt + 4'd1;
                end else if (scl_fall) begin
                    if (bit_cnt == 4'd8) begin
                        oe_nxt      = 1'b0;
                        bit_cnt_nxt = '0;
                        state_nxt   = RDATA_ACK;
                    end else begin
                        oe_nxt    = ~shreg[6];
                        shreg_nxt = {shreg[6:0], 1'b0};
                    end
                end

                RDATA_ACK: if (scl_rise) begin
                    if (sda_lvl) begin
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                    end else begin
                        addr_nxt    = cur_addr + ADDR_W'(1);
                        bit_cnt_nxt = 4'd1;
                    end
                end else if (scl_fall && bit_cnt == 4'd1) begin
                    state_nxt   = RDATA;
                    bit_cnt_nxt = '0;
                    shreg_nxt   = rd_data;
                    oe_nxt      = ~rd_data[7];
                end

                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// ---------------------------------------------------------------------------
// tb_i2c_eeprom_slave
// Directed bench for i2c_eeprom_slave: a bit-banged I2C master on a
// wired-AND SDA line, with hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_i2c_eeprom_slave;

    localparam int QP = 8;   // clk cycles per quarter SCL period

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m_scl = 1'b1;
    logic        m_sda_low = 1'b0;
    logic        sda_line;
    logic        sda_oe, busy, wr_pulse;
    logic [10:0] cur_addr;
`ifdef WRITE_PROTECT_EN
    logic        wp = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;

    assign sda_line = ~(m_sda_low | sda_oe);

    i2c_eeprom_slave #(
        .ADDR_W      (11),
        .DEV_ID      (4'b1010),
        .PAGE_W      (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_i    (m_scl),
        .sda_i    (sda_line),
`ifdef WRITE_PROTECT_EN
        .wp       (wp),
`endif
        .sda_oe   (sda_oe),
        .busy     (busy),
        .wr_pulse (wr_pulse),
        .cur_addr (cur_addr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (wr_pulse === 1'b1) wr_cnt++;

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic qwait();
        repeat (QP) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0; qwait();
        m_scl = 1'b1;     qwait();
        m_sda_low = 1'b1; qwait();
        m_scl = 1'b0;     qwait();
    endtask

    task automatic i2c_stop();
        m_scl = 1'b0;
        m_sda_low = 1'b1; qwait();
        m_scl = 1'b1;     qwait();
        m_sda_low = 1'b0; qwait();
    endtask

    task automatic send_bit(input logic b);
        m_sda_low = ~b; qwait();
        m_scl = 1'b1;   qwait(); qwait();
        m_scl = 1'b0;   qwait();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 0; i < 8; i++) send_bit(d[7-i]);
        m_sda_low = 1'b0; qwait();
        m_scl = 1'b1;     qwait();
        ack = (sda_line === 1'b0);
        qwait();
        m_scl = 1'b0;     qwait();
    endtask

    task automatic read_byte(input logic do_ack, output logic [7:0] d);
        d = '0;
        m_sda_low = 1'b0;
        for (int i = 0; i < 8; i++) begin
            qwait();
            m_scl = 1'b1; qwait();
            d = {d[6:0], sda_line};
            qwait();
            m_scl = 1'b0;
        end
        qwait();
        m_sda_low = do_ack; qwait();
        m_scl = 1'b1;       qwait(); qwait();
        m_scl = 1'b0;       qwait();
        m_sda_low = 1'b0;
    endtask

    task automatic mem_write(input string tag, input logic [7:0] ctrl,
                             input logic [7:0] addr, input logic [7:0] data);
        logic a;
        i2c_start();
        write_byte(ctrl, a); check({tag, " ctrl ack"}, 32'(a), 32'd1);
        write_byte(addr, a); check({tag, " addr ack"}, 32'(a), 32'd1);
        write_byte(data, a); check({tag, " data ack"}, 32'(a), 32'd1);
        i2c_stop();
    endtask

    task automatic rand_read(input string tag, input logic [7:0] ctrl,
                             input logic [7:0] addr, output logic [7:0] d);
        logic a;
        i2c_start();
        write_byte(ctrl & 8'hFE, a); check({tag, " ctrlw ack"}, 32'(a), 32'd1);
        write_byte(addr, a);         check({tag, " addr ack"}, 32'(a), 32'd1);
        i2c_start();
        write_byte(ctrl | 8'h01, a); check({tag, " ctrlr ack"}, 32'(a), 32'd1);
        read_byte(1'b0, d);
        i2c_stop();
    endtask

    initial begin
        logic       a;
        logic [7:0] d;
        int         wr_base;

        // Reset state
        repeat (4) @(negedge clk);
        check("rst sda_oe",   32'(sda_oe),   32'd0);
        check("rst busy",     32'(busy),     32'd0);
        check("rst wr_pulse", 32'(wr_pulse), 32'd0);
        check("rst cur_addr", 32'(cur_addr), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Byte write 0x035 <- 0x5A
        wr_base = wr_cnt;
        i2c_start();
        write_byte(8'hA0, a); check("bw ctrl ack", 32'(a), 32'd1);
        check("bw busy", 32'(busy), 32'd1);
        write_byte(8'h35, a); check("bw addr ack", 32'(a), 32'd1);
        write_byte(8'h5A, a); check("bw data ack", 32'(a), 32'd1);
        i2c_stop();
        check("bw wr_pulse count", 32'(wr_cnt - wr_base), 32'd1);
        check("bw busy after stop", 32'(busy), 32'd0);
        check("bw cur_addr", 32'(cur_addr), 32'h036);
        rand_read("bw rd", 8'hA0, 8'h35, d);
        check("bw readback", 32'(d), 32'h5A);
        check("bw rd cur_addr", 32'(cur_addr), 32'h035);

        // Block select: 0x310 <- 0xC3
        mem_write("blk", 8'hA6, 8'h10, 8'hC3);
        check("blk cur_addr", 32'(cur_addr), 32'h311);
        rand_read("blk rd", 8'hA6, 8'h10, d);
        check("blk readback", 32'(d), 32'hC3);

        // Page wrap from 0x00E; 0x010 preloaded and must survive
        mem_write("pre010", 8'hA0, 8'h10, 8'h99);
        wr_base = wr_cnt;
        i2c_start();
        write_byte(8'hA0, a); check("pw ctrl ack", 32'(a), 32'd1);
        write_byte(8'h0E, a); check("pw addr ack", 32'(a), 32'd1);
        write_byte(8'h11, a); check("pw d0 ack", 32'(a), 32'd1);
        write_byte(8'h22, a); check("pw d1 ack", 32'(a), 32'd1);
        write_byte(8'h33, a); check("pw d2 ack", 32'(a), 32'd1);
        i2c_stop();
        check("pw wr_pulse count", 32'(wr_cnt - wr_base), 32'd3);
        check("pw cur_addr", 32'(cur_addr), 32'h001);
        i2c_start();
        write_byte(8'hA0, a); check("pw rd ctrlw ack", 32'(a), 32'd1);
        write_byte(8'h0E, a); check("pw rd addr ack", 32'(a), 32'd1);
        i2c_start();
        write_byte(8'hA1, a); check("pw rd ctrlr ack", 32'(a), 32'd1);
        read_byte(1'b1, d); check("pw mem 00E", 32'(d), 32'h11);
        read_byte(1'b1, d); check("pw mem 00F", 32'(d), 32'h22);
        read_byte(1'b0, d); check("pw mem 010", 32'(d), 32'h99);
        i2c_stop();
        rand_read("pw rd0", 8'hA0, 8'h00, d);
        check("pw mem 000", 32'(d), 32'h33);

        // Sequential read across the top of memory
        i2c_start();
        write_byte(8'hAE, a); check("sq ctrl ack", 32'(a), 32'd1);
        write_byte(8'hFE, a); check("sq addr ack", 32'(a), 32'd1);
        write_byte(8'hA1, a); check("sq d0 ack", 32'(a), 32'd1);
        write_byte(8'hB2, a); check("sq d1 ack", 32'(a), 32'd1);
        i2c_stop();
        mem_write("sq pre001", 8'hA0, 8'h01, 8'h44);
        i2c_start();
        write_byte(8'hAE, a); check("sq rd ctrlw ack", 32'(a), 32'd1);
        write_byte(8'hFE, a); check("sq rd addr ack", 32'(a), 32'd1);
        i2c_start();
        write_byte(8'hAF, a); check("sq rd ctrlr ack", 32'(a), 32'd1);
        read_byte(1'b1, d); check("sq mem 7FE", 32'(d), 32'hA1);
        read_byte(1'b1, d); check("sq mem 7FF", 32'(d), 32'hB2);
        read_byte(1'b1, d); check("sq mem 000", 32'(d), 32'h33);
        read_byte(1'b0, d); check("sq mem 001", 32'(d), 32'h44);
        check("sq busy after nack", 32'(busy), 32'd0);
        check("sq cur_addr", 32'(cur_addr), 32'h001);
        i2c_stop();

        // Foreign device address
        i2c_start();
        write_byte(8'h90, a); check("fa ack", 32'(a), 32'd0);
        check("fa busy", 32'(busy), 32'd0);
        write_byte(8'h00, a); check("fa idle ack", 32'(a), 32'd0);
        i2c_stop();

        // STOP after 5 data bits discards the byte
        mem_write("ab pre040", 8'hA0, 8'h40, 8'h5C);
        wr_base = wr_cnt;
        i2c_start();
        write_byte(8'hA0, a); check("ab ctrl ack", 32'(a), 32'd1);
        write_byte(8'h40, a); check("ab addr ack", 32'(a), 32'd1);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        i2c_stop();
        check("ab wr_pulse count", 32'(wr_cnt - wr_base), 32'd0);
        check("ab cur_addr", 32'(cur_addr), 32'h040);
        rand_read("ab rd", 8'hA0, 8'h40, d);
        check("ab readback", 32'(d), 32'h5C);

        // Reset mid-read: 0x035 holds 0x5A, MSB 0 so SDA is pulled
        i2c_start();
        write_byte(8'hA0, a); check("rr ctrlw ack", 32'(a), 32'd1);
        write_byte(8'h35, a); check("rr addr ack", 32'(a), 32'd1);
        i2c_start();
        write_byte(8'hA1, a); check("rr ctrlr ack", 32'(a), 32'd1);
        check("rr sda_oe driving", 32'(sda_oe), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rr sda_oe released", 32'(sda_oe), 32'd0);
        check("rr busy", 32'(busy), 32'd0);
        check("rr cur_addr", 32'(cur_addr), 32'd0);
        rst_n = 1'b1;
        i2c_stop();
        rand_read("rr rd", 8'hA0, 8'h35, d);
        check("rr mem kept", 32'(d), 32'h5A);

`ifdef WRITE_PROTECT_EN
        // Write protect: data byte NACKed, memory unchanged
        mem_write("wp pre020", 8'hA0, 8'h20, 8'h66);
        wp = 1'b1;
        wr_base = wr_cnt;
        i2c_start();
        write_byte(8'hA0, a); check("wp ctrl ack", 32'(a), 32'd1);
        write_byte(8'h20, a); check("wp addr ack", 32'(a), 32'd1);
        write_byte(8'h77, a); check("wp data nack", 32'(a), 32'd0);
        i2c_stop();
        check("wp wr_pulse count", 32'(wr_cnt - wr_base), 32'd0);
        wp = 1'b0;
        rand_read("wp rd", 8'hA0, 8'h20, d);
        check("wp mem 020", 32'(d), 32'h66);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_eeprom_slave.md
Name: i2c_eeprom_slave

Overview:
- Synthesizable, clocked I2C slave memory; next generation of the team's behavioural serial EEPROM model.
- Oversamples SCL/SDA on a system clock.
- Parametrised memory depth, block-select bits and page size.
- Adds page write, sequential/current-address read, ACK/NACK generation and open-drain SDA drive; sits behind the board-level I2C pads in SoC test benches and FPGA demos.

Parameters:
- ADDR_W, 11, word address width (8..11); upper ADDR_W-8 bits come from control byte bits [3:1]
- DEV_ID, 4'b1010, control byte bits [7:4] that select this device
- PAGE_W, 4, log2 of page size (16-byte pages) for page-write wrap
- SYNC_STAGES, 2, synchronizer depth on scl_i/sda_i (>=2)

Ports:
- clk  input  1  system clock, >=16x SCL rate
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- scl_i  input  1  SCL pin level
- sda_i  input  1  SDA pin level
- sda_oe  output  1  1 = pull SDA low (open drain); 0 = release
- busy  output  1  high from addressed START until STOP/NACK-abort
- wr_pulse  output  1  one-clk pulse per byte committed to memory
- cur_addr  output  ADDR_W  internal address pointer

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - sda_oe=0, busy=0, wr_pulse=0, cur_addr=0
  - FSM goes to IDLE; memory contents are not cleared.
- Reset mid-transfer: SDA is released on the next clk.
- Inputs pass through SYNC_STAGES flops. Edge detection uses the synchronized previous/current levels.
- START: SDA falls while SCL high. STOP: SDA rises while SCL high. Both are recognised in any state.
  - START → CTRL, bit counter=0.
  - STOP → IDLE, busy=0, sda_oe=0.
- Data bits are sampled on the SCL rising edge, MSB first.
- The slave changes sda_oe only on the clk after a detected SCL falling edge.
- FSM states and transitions:
  - IDLE: waits for START.
  - CTRL: shift 8 bits.
    - If bits[7:4]==DEV_ID → CTRL_ACK.
    - Otherwise → IDLE (no ACK, sda_oe stays 0).
    - Block bits [3:1] are latched into cur_addr[ADDR_W-1:8]; unused bits are ignored when ADDR_W<11.
    - R/W=0 → ADDR after ACK. R/W=1 → RDATA after ACK (current-address read).
  - CTRL_ACK / ADDR_ACK / WDATA_ACK: sda_oe=1 from the SCL fall after bit 8 until the next SCL fall.
  - ADDR: 8 bits → cur_addr[7:0] → ADDR_ACK → WDATA.
  - WDATA: 8 bits.
    - Write memory[cur_addr] on the clk following the 8th rising edge; pulse wr_pulse.
    - Increment only cur_addr[PAGE_W-1:0], so the pointer wraps within the page; upper bits are unchanged.
    - Then WDATA_ACK → WDATA.
  - Repeated START during ADDR_ACK/WDATA: → CTRL with the pointer kept. This is a random read when the next ctrl has R/W=1.
  - RDATA:
    - memory[cur_addr] is loaded into the shift register at entry.
    - sda_oe = ~bit, updated on each SCL fall; 8 bits.
    - Then release SDA → RDATA_ACK.
  - RDATA_ACK: sample SDA on the SCL rise.
    - 0 (master ACK): cur_addr increments, wrapping at 2^ADDR_W-1 → 0, then → RDATA.
    - 1 (NACK): → IDLE with busy=0.
- Simultaneous START/STOP with a data edge: START/STOP take priority.
- A write is committed only when all 8 bits were received. STOP mid-byte discards the partial byte.
- Memory is a single-port array of 2^ADDR_W x 8, with registered read.

Optional Feature:
- Macro WRITE_PROTECT_EN.
- Defined:
  - Adds input port wp (1 bit, synchronized like scl_i).
  - While wp=1, WDATA bytes are NACKed (sda_oe stays 0 in WDATA_ACK), memory is unchanged, and wr_pulse stays 0.
  - Control and address bytes are still ACKed.
- Undefined: no wp port; all writes are accepted.

Decomposition:
- Package i2c_eeprom_pkg holds:
  - state enum (IDLE, CTRL, CTRL_ACK, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK)
  - CTRL_RW_BIT=0
  - BLOCK_LSB=1
- Sub-module i2c_line_cond: synchronizers plus scl_rise/scl_fall/start/stop detection. The top level holds the FSM, shifter and memory.

Test Plan:
- Byte write: START, 0xA0, 0x35, 0x5A, STOP → three ACKs; wr_pulse once; a later random read of 0x035 returns 0x5A.
- Block select with ADDR_W=11: ctrl 0xA6, addr 0x10, data 0xC3 → memory[0x310]=0xC3; cur_addr=0x311.
- Page wrap with PAGE_W=4: write 3 bytes 0x11,0x22,0x33 starting at 0x00E → locations 0x00E, 0x00F, 0x000 hold them; 0x010 unchanged.
- Sequential read from 0x7FE: master ACKs 3 bytes then NACKs → data of 0x7FE, 0x7FF, 0x000, 0x001; busy drops after the NACK.
- Foreign address and abort:
  - ctrl 0x90 → no ACK, FSM returns to IDLE.
  - STOP after 5 data bits → no write.
  - rst_n low mid-read → sda_oe=0 next clk.
- WRITE_PROTECT_EN, wp=1: write 0xA0, 0x20, 0x77 → data byte NACKed; memory[0x020] is unchanged.
